rr_fifo_arbiter: RTL and testbench
==================================

Name: rr_fifo_arbiter

Overview:
- Sits directly downstream of four input FIFOs (one per traffic class) and upstream of four destination FIFOs.
- Issues at most one pop per cycle to the input FIFOs, round-robin among non-empty sources.
- Captures the popped word when the source FIFO marks it valid and routes it to one of four destination FIFOs, selected by the word's two class MSBs.
- Stalls all pops while any destination signals pause.

Parameters:
- BITNUMBER, 6, word width; must be ≥3. Class field is data[BITNUMBER-1:BITNUMBER-2].
- MAX_INFLIGHT, 3, maximum number of pops issued but not yet returned valid.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- fifo_empty  in  4  per-source empty flag, bit i = source i.
- fifo_almost_empty  in  4  per-source one-entry-left flag.
- fifo_valid  in  4  per-source read-data-valid strobe.
- fifo_data0..fifo_data3  in  BITNUMBER each  per-source read data, sampled only when the matching fifo_valid bit is 1.
- dest_pause  in  4  per-destination pause, bit j = destination j.
- fifo_rd  out  4  one-hot (or zero) pop strobe to the sources.
- data_out  out  BITNUMBER  word forwarded to the destinations.
- push  out  4  one-hot (or zero) write strobe to the destinations.
- state  out  2  FSM state encoding.
- idle  out  1  1 when all sources are empty and nothing is in flight.
- err_collision  out  1  sticky error flag.

Behaviour:
- Reset values (reset=0, asynchronous):
  - fifo_rd=0, push=0, data_out=0, state=IDLE (2'b00), idle=1, err_collision=0.
  - rr_ptr=0, last_pop=none, inflight=0.
- Eligibility: source i is eligible when fifo_empty[i]=0, AND NOT (last_pop==i in the previous cycle AND fifo_almost_empty[i]=1). This blocks a stale-flag double pop of the last entry.
- Grant selection:
  - Search i = rr_ptr, rr_ptr+1, … mod 4; the first eligible source wins.
  - On a grant, fifo_rd[i]=1 for exactly one cycle (registered output) and rr_ptr <= (i+1) mod 4.
  - With no grant, rr_ptr holds.
- Pop gating: no pop is issued while |dest_pause=1 or inflight==MAX_INFLIGHT.
- inflight counter:
  - +1 per pop, −1 per valid return, net 0 when both happen in the same cycle.
  - Saturates; it never underflows. A valid with inflight==0 is still forwarded.
- Return path, 1-cycle latency from fifo_valid:
  - data_out <= fifo_dataK and push[data_out class] <= 1, where K is the asserted valid bit.
  - push deasserts the next cycle unless another valid arrives. data_out holds its last value when push=0.
- Collision: if more than one fifo_valid bit is high in a cycle, the lowest index is forwarded, the others are dropped, and err_collision <= 1. The flag clears only on reset.
- Pause affects only pops. Words already in flight are always pushed, even to a paused destination; destination FIFOs absorb these words, and pause acts as an almost-full threshold.
- FSM states:
  - IDLE (00): all sources empty and inflight==0. idle=1.
  - RUN (01): pops being issued or in flight.
  - PAUSED (10): |dest_pause=1.
  - Transitions:
    - IDLE→RUN when any fifo_empty bit is 0 and no pause.
    - any→PAUSED when |dest_pause.
    - PAUSED→RUN when the pause clears and work remains.
    - RUN/PAUSED→IDLE when all empty, inflight==0 and no pause.
  - idle is registered and equals (state==IDLE).
- Async reset mid-transfer: outstanding returns arriving after reset deassertion are forwarded normally. inflight restarts at 0 and saturates at 0.

Test Plan:
- Reset: drive reset=0 mid-activity → fifo_rd=0, push=0, data_out=0, state=00, idle=1, err_collision=0, applied without waiting for a clk edge.
- Round-robin fairness:
  - Stimulus: all four sources non-empty, almost_empty=0, no pause, 8 cycles.
  - Required: fifo_rd = 0001, 0010, 0100, 1000, 0001, …
  - Required: never two bits high at once.
- Routing and latency:
  - Stimulus: fifo_valid=0100 with fifo_data2=6'b10_1101.
  - Required, next cycle: data_out=6'b101101, push=0100.
  - Required, cycle after: push=0000.
- Pause stall:
  - Stimulus: dest_pause=0010 while sources are non-empty.
  - Required: fifo_rd stays 0000 and state=10.
  - Required: pending valids are still pushed.
  - Required: pause release → pops resume from the held rr_ptr.
- Last-entry guard:
  - Stimulus: only source 3 non-empty, almost_empty[3]=1.
  - Required: fifo_rd=1000 once, then 0000 the next cycle.
  - Required: a pop is allowed again only after almost_empty[3]=0 or empty[3]=1.
- Collision and in-flight limit:
  - Stimulus 1: fifo_valid=0101.
  - Required: data_out=fifo_data0, push per source-0 class, err_collision=1 and stays 1.
  - Stimulus 2: three pops issued with no returns.
  - Required: no fourth pop until a valid arrives.

Source files
------------

// File: rtl/rr_fifo_arbiter.sv
// Round-robin pop arbiter over four source FIFOs; routes each returned word to one of four
// destination FIFOs selected by the word's two class MSBs.
module rr_fifo_arbiter #(
  parameter int unsigned BITNUMBER    = 6,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           fifo_empty,
  input  logic [3:0]           fifo_almost_empty,
  input  logic [3:0]           fifo_valid,
  input  logic [BITNUMBER-1:0] fifo_data0,
  input  logic [BITNUMBER-1:0] fifo_data1,
  input  logic [BITNUMBER-1:0] fifo_data2,
  input  logic [BITNUMBER-1:0] fifo_data3,
  input  logic [3:0]           dest_pause,
  output logic [3:0]           fifo_rd,
  output logic [BITNUMBER-1:0] data_out,
  output logic [3:0]           push,
  output logic [1:0]           state,
  output logic                 idle,
  output logic                 err_collision
);

  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StPaused = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           fifo_rd_q, fifo_rd_d;
  logic [3:0]           push_q, push_d;
  logic [BITNUMBER-1:0] data_out_q, data_out_d;
  logic                 idle_q, idle_d;
  logic                 err_q, err_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic                 last_vld_q, last_vld_d;
  logic [1:0]           last_idx_q, last_idx_d;
  logic [CntW-1:0]      inflight_q, inflight_d;

  logic [3:0]           elig;
  logic                 pop_gate;
  logic [2:0]           grant;
  logic [2:0]           val_sel;
  logic [BITNUMBER-1:0] src_data [4];
  logic [BITNUMBER-1:0] sel_data;
  logic [1:0]           sel_cls;
  logic                 collision;

  // Returns {hit, index} of the first set bit of req, searching upward from ptr with wrap.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign src_data[0] = fifo_data0;
  assign src_data[1] = fifo_data1;
  assign src_data[2] = fifo_data2;
  assign src_data[3] = fifo_data3;

  // The guard on the last popped source holds until its flags show the entry has drained
  // (empty) or more than one entry remains (almost_empty low).
  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = !fifo_empty[i] &&
                !(last_vld_q && (last_idx_q == 2'(i)) && fifo_almost_empty[i]);
    end
  end

  assign pop_gate  = (|dest_pause) || (inflight_q == CntW'(MAX_INFLIGHT));
  assign grant     = pop_gate ? 3'b000 : rr_pick(elig, rr_ptr_q);
  assign val_sel   = rr_pick(fifo_valid, 2'd0);
  assign sel_data  = src_data[val_sel[1:0]];
  assign sel_cls   = sel_data[BITNUMBER-1 -: 2];
  assign collision = (fifo_valid & (fifo_valid - 4'd1)) != 4'd0;

  always_comb begin
    fifo_rd_d  = 4'b0000;
    push_d     = 4'b0000;
    data_out_d = data_out_q;
    err_d      = err_q | collision;
    rr_ptr_d   = rr_ptr_q;
    last_vld_d = last_vld_q;
    last_idx_d = last_idx_q;
    inflight_d = inflight_q;
    state_d    = state_q;

    if (grant[2]) begin
      fifo_rd_d[grant[1:0]] = 1'b1;
      rr_ptr_d              = grant[1:0] + 2'd1;
      last_vld_d            = 1'b1;
      last_idx_d            = grant[1:0];
    end else if (last_vld_q &&
                 (fifo_empty[last_idx_q] || !fifo_almost_empty[last_idx_q])) begin
      last_vld_d = 1'b0;
    end

    if (val_sel[2]) begin
      data_out_d      = sel_data;
      push_d[sel_cls] = 1'b1;
    end

    // Pop and return in the same cycle cancel; a return with nothing counted is ignored.
    if (grant[2] && !val_sel[2]) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!grant[2] && val_sel[2] && (inflight_q != '0)) begin
      inflight_d = inflight_q - CntW'(1);
    end

    if (|dest_pause) begin
      state_d = StPaused;
    end else if ((&fifo_empty) && (inflight_q == '0)) begin
      state_d = StIdle;
    end else begin
      state_d = StRun;
    end
    idle_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      fifo_rd_q  <= 4'b0000;
      push_q     <= 4'b0000;
      data_out_q <= '0;
      idle_q     <= 1'b1;
      err_q      <= 1'b0;
      rr_ptr_q   <= 2'd0;
      last_vld_q <= 1'b0;
      last_idx_q <= 2'd0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      fifo_rd_q  <= fifo_rd_d;
      push_q     <= push_d;
      data_out_q <= data_out_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      rr_ptr_q   <= rr_ptr_d;
      last_vld_q <= last_vld_d;
      last_idx_q <= last_idx_d;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_rd       = fifo_rd_q;
  assign push          = push_q;
  assign data_out      = data_out_q;
  assign state         = state_q;
  assign idle          = idle_q;
  assign err_collision = err_q;

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed bench for rr_fifo_arbiter: a queue-free cycle model predicts every output each
// cycle, and literal expectations pin the model at the interesting points.
module tb_rr_fifo_arbiter;

  localparam int BW   = 6;
  localparam int MAXF = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    fifo_empty, fifo_almost_empty, fifo_valid, dest_pause;
  logic [BW-1:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
  logic [3:0]    fifo_rd, push;
  logic [BW-1:0] data_out;
  logic [1:0]    state;
  logic          idle, err_collision;

  int checks = 0;
  int errors = 0;

  // Model state
  int            m_rr, m_last, m_inflight, m_state;
  logic [3:0]    m_rd, m_push;
  logic [BW-1:0] m_data;
  logic          m_idle, m_err;

  rr_fifo_arbiter #(.BITNUMBER(BW), .MAX_INFLIGHT(MAXF)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_valid        (fifo_valid),
    .fifo_data0        (fifo_data0),
    .fifo_data1        (fifo_data1),
    .fifo_data2        (fifo_data2),
    .fifo_data3        (fifo_data3),
    .dest_pause        (dest_pause),
    .fifo_rd           (fifo_rd),
    .data_out          (data_out),
    .push              (push),
    .state             (state),
    .idle              (idle),
    .err_collision     (err_collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_last = -1; m_inflight = 0; m_state = 0;
    m_rd = 4'b0000; m_push = 4'b0000; m_data = '0; m_idle = 1'b1; m_err = 1'b0;
  endtask

  task automatic model_step();
    int            g, nv, fv, s;
    logic [BW-1:0] d [4];
    d[0] = fifo_data0; d[1] = fifo_data1; d[2] = fifo_data2; d[3] = fifo_data3;
    g = -1;
    if (dest_pause == 4'b0000 && m_inflight < MAXF) begin
      for (int k = 0; k < 4; k++) begin
        s = (m_rr + k) % 4;
        if (g < 0 && !fifo_empty[s] && !(m_last == s && fifo_almost_empty[s])) g = s;
      end
    end
    nv = 0; fv = -1;
    for (int i = 0; i < 4; i++) begin
      if (fifo_valid[i]) begin
        nv++;
        if (fv < 0) fv = i;
      end
    end
    if (dest_pause != 4'b0000) m_state = 2;
    else if (fifo_empty == 4'b1111 && m_inflight == 0) m_state = 0;
    else m_state = 1;
    m_idle = (m_state == 0);
    m_rd = (g >= 0) ? 4'(1 << g) : 4'b0000;
    if (nv > 0) begin
      m_data = d[fv];
      m_push = 4'(1 << (d[fv] / 16));
    end else begin
      m_push = 4'b0000;
    end
    if (nv > 1) m_err = 1'b1;
    m_inflight = m_inflight + ((g >= 0) ? 1 : 0) - ((nv > 0) ? 1 : 0);
    if (m_inflight < 0) m_inflight = 0;
    if (g >= 0) m_last = g;
    else if (m_last >= 0 && (fifo_empty[m_last] || !fifo_almost_empty[m_last])) m_last = -1;
    if (g >= 0) m_rr = (g + 1) % 4;
  endtask

  // Advance one clock and compare every output against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("fifo_rd", 32'(fifo_rd), 32'(m_rd));
    check("rd_onehot", 32'($countones(fifo_rd) <= 1), 32'd1);
    check("push", 32'(push), 32'(m_push));
    check("data_out", 32'(data_out), 32'(m_data));
    check("state", 32'(state), 32'(m_state));
    check("idle", 32'(idle), 32'(m_idle));
    check("err_collision", 32'(err_collision), 32'(m_err));
  endtask

  task automatic check_reset_vals();
    check("rst_fifo_rd", 32'(fifo_rd), 32'h0);
    check("rst_push", 32'(push), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_err", 32'(err_collision), 32'h0);
  endtask

  initial begin
    logic [3:0] rr_exp [8];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    fifo_empty = 4'b1111; fifo_almost_empty = 4'b0000; fifo_valid = 4'b0000;
    dest_pause = 4'b0000;
    fifo_data0 = '0; fifo_data1 = '0; fifo_data2 = '0; fifo_data3 = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_reset_vals();
    model_reset();
    #2 reset = 1'b1;
    tick();

    // Round-robin with a steady return stream so the in-flight limit never bites
    fifo_empty = 4'b0000; fifo_valid = 4'b0001; fifo_data0 = 6'b00_0011;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("rr_order", 32'(fifo_rd), 32'(rr_exp[n]));
    end

    // Routing and latency
    fifo_empty = 4'b1111; fifo_valid = 4'b0100; fifo_data2 = 6'b10_1101;
    tick();
    check("route_data", 32'(data_out), 32'h2d);
    check("route_push", 32'(push), 32'h4);
    fifo_valid = 4'b0000;
    tick();
    check("route_push_off", 32'(push), 32'h0);

    // Pause stall: move rr_ptr to 2 first
    fifo_empty = 4'b1101;
    tick();
    check("pre_pause_rd", 32'(fifo_rd), 32'h2);
    fifo_empty = 4'b0000; dest_pause = 4'b0010; fifo_valid = 4'b1000; fifo_data3 = 6'b01_0000;
    tick();
    check("pause_rd", 32'(fifo_rd), 32'h0);
    check("pause_state", 32'(state), 32'h2);
    check("pause_push", 32'(push), 32'h2);
    fifo_valid = 4'b0000;
    tick();
    dest_pause = 4'b0000;
    tick();
    check("resume_rd", 32'(fifo_rd), 32'h4);
    check("resume_state", 32'(state), 32'h1);

    // Last-entry guard on source 3
    fifo_empty = 4'b1111; fifo_valid = 4'b0001; fifo_data0 = 6'b11_1111;
    tick();
    check("drain_push", 32'(push), 32'h8);
    fifo_empty = 4'b0111; fifo_almost_empty = 4'b1000; fifo_valid = 4'b0000;
    tick();
    check("guard_first", 32'(fifo_rd), 32'h8);
    tick();
    check("guard_block1", 32'(fifo_rd), 32'h0);
    tick();
    check("guard_block2", 32'(fifo_rd), 32'h0);
    fifo_almost_empty = 4'b0000;
    tick();
    check("guard_ae_clear", 32'(fifo_rd), 32'h8);
    fifo_empty = 4'b1111;
    tick();
    fifo_empty = 4'b0111; fifo_almost_empty = 4'b1000;
    tick();
    check("guard_empty_clear", 32'(fifo_rd), 32'h8);

    // Collision
    fifo_empty = 4'b1111; fifo_almost_empty = 4'b0000;
    fifo_valid = 4'b0101; fifo_data0 = 6'b01_0101; fifo_data2 = 6'b11_0000;
    tick();
    check("coll_data", 32'(data_out), 32'h15);
    check("coll_push", 32'(push), 32'h2);
    check("coll_err", 32'(err_collision), 32'h1);
    fifo_valid = 4'b0000;
    tick();
    check("coll_sticky", 32'(err_collision), 32'h1);
    fifo_valid = 4'b0010; fifo_data1 = 6'b00_0001;
    tick();
    fifo_valid = 4'b1000; fifo_data3 = 6'b10_0000;
    tick();

    // In-flight limit
    fifo_empty = 4'b0000; fifo_valid = 4'b0000;
    tick(); check("lim_pop1", 32'(fifo_rd), 32'h1);
    tick(); check("lim_pop2", 32'(fifo_rd), 32'h2);
    tick(); check("lim_pop3", 32'(fifo_rd), 32'h4);
    tick(); check("lim_hold1", 32'(fifo_rd), 32'h0);
    tick(); check("lim_hold2", 32'(fifo_rd), 32'h0);
    fifo_valid = 4'b0001; fifo_data0 = 6'b00_0111;
    tick(); check("lim_ret_rd", 32'(fifo_rd), 32'h0);
    fifo_valid = 4'b0000;
    tick(); check("lim_resume", 32'(fifo_rd), 32'h8);

    // Asynchronous reset mid-activity, then a late return
    #2 reset = 1'b0;
    #1 check_reset_vals();
    model_reset();
    #1 reset = 1'b1;
    fifo_empty = 4'b1111; fifo_valid = 4'b0100; fifo_data2 = 6'b01_1110;
    tick();
    check("late_push", 32'(push), 32'h2);
    check("late_data", 32'(data_out), 32'h1e);
    fifo_valid = 4'b0000;
    tick();
    fifo_empty = 4'b0000;
    tick();
    check("post_rst_rr", 32'(fifo_rd), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
